mem_readback_engine: RTL
========================

Name: mem_readback_engine

Overview:
- Memory-bus initiator that reads a byte range out of DRAM and emits it as a ready/valid byte stream.
- It is the read-out counterpart of the program/data image loader at CODE_SEGMENT_START and DATA_SEGMENT_START.
- Used for result dumps, checksum/compare against the .bin and .bin.data images, and debug trace.
- Sits beside the fetch stage on the memory bus and is arbitrated as one more requester.

Parameters:
- ADDR_W, 21: physical byte address width; matches phys_memory_address_t.
- WORD_BYTES, 8: bytes per memory-bus data beat (64-bit).
- LEN_W, 22: width of the byte-count request; allows a full 2^21-byte dump.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- start_addr  in  ADDR_W  first byte address; any alignment allowed.
- byte_count  in  LEN_W  number of bytes to emit.
- busy  out  1  high from accepted start until the last byte handshakes.
- done  out  1  one-cycle pulse after the last byte, or immediately for a zero-length start.
- err  out  1  sticky; set on an unexpected response; cleared only by reset.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  bus accepts the request.
- mem_req_addr  out  ADDR_W  word-aligned address; low log2(WORD_BYTES) bits are always 0.
- mem_rsp_valid  in  1  read data valid; no backpressure.
- mem_rsp_data  in  64  read data, little-endian (byte k = bits 8k+7:8k).
- out_valid  out  1  byte available.
- out_ready  in  1  consumer accepts the byte.
- out_data  out  8  byte value.
- out_last  out  1  high with the final byte of the dump.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE.
  - busy, done, err, mem_req_valid, out_valid and out_last = 0.
  - mem_req_addr, out_data and internal counters = 0.
- Outstanding requests: at most one at any time.
- IDLE:
  - start && byte_count==0: done=1 for the next cycle, stay IDLE, no bus traffic.
  - start && byte_count!=0: latch cur_word = start_addr with low bits cleared, skip = start_addr[2:0], remaining = byte_count; go to ISSUE.
  - busy is high from the following cycle.
- ISSUE:
  - mem_req_valid=1, mem_req_addr=cur_word; address and valid stay stable until ready.
  - On mem_req_valid && mem_req_ready: go to WAIT.
- WAIT:
  - On mem_rsp_valid: latch the 64-bit word into the buffer, byte index = skip, then skip=0.
  - Go to DRAIN.
  - Minimum latency from start to first out_valid: 3 cycles with a zero-wait bus (ISSUE, WAIT, DRAIN).
- DRAIN:
  - out_valid=1, out_data = buffer byte[index], out_last = (remaining==1).
  - On out_valid && out_ready: remaining -= 1, index += 1.
  - If remaining becomes 0: pulse done, drop busy, go to IDLE.
  - Else if index wraps past WORD_BYTES-1: cur_word += WORD_BYTES (modulo 2^ADDR_W, wraps to 0 silently), go to ISSUE.
  - Else stay in DRAIN.
  - out_data and out_last hold stable while out_valid && !out_ready.
- No prefetch: the next request is issued only after the current word is fully drained. Keeping one outstanding request and a single buffer is intentional.
- Unexpected mem_rsp_valid in IDLE, ISSUE or DRAIN: response is ignored, err=1.
- start while busy: ignored; no error raised.
- Reset mid-operation: all state is abandoned and out_valid drops immediately.
  - A response already in flight that arrives after reset deassertion lands in IDLE and sets err.
  - Integration must reset the bus and this block together.
- Throughput with a zero-wait bus and out_ready held high: WORD_BYTES bytes per WORD_BYTES+2 cycles.

Decomposition:
- Shared package (beside Defines.sv):
  - phys_memory_address_t; WORD_BYTES; CODE_SEGMENT_START and DATA_SEGMENT_START.
  - A mem_read_req_t struct {valid, addr} for reuse by the fetch stage and arbiter.
  - The readback FSM state enum.
- One sub-module is natural: word_to_byte_unpacker.
  - Contains the 64-bit buffer, byte index, skip load, and ready/valid byte output.
  - Exposes word_load, word_empty and the out_* stream.
  - The parent keeps the FSM, address counter and remaining counter.

Test Plan:
- Aligned dump: start_addr=0x1000, byte_count=8, memory word 0x8877665544332211, out_ready=1.
  - Bytes 11,22,...,88; one bus request to 0x1000; out_last on 0x88; done pulses one cycle after.
- Unaligned cross-word: start_addr=0x1005, byte_count=6, word@0x1000 = 0x..., word@0x1008 = 0x...
  - Requests to 0x1000 then 0x1008; bytes are @0x1000 bytes 5..7 then @0x1008 bytes 0..2; exactly 6 handshakes.
- Backpressure on both sides: out_ready toggles 1,0,0,1 and mem_req_ready is held low for 3 cycles.
  - Request address/valid stable while stalled; out_data stable while stalled; no byte lost or duplicated.
- Zero length: start, byte_count=0.
  - done=1 next cycle, busy stays 0, mem_req_valid never asserts.
- Address wrap: start_addr=0x1FFFF8, byte_count=16.
  - Requests to 0x1FFFF8 then 0x000000; 16 bytes emitted; err stays 0.
- Errors and reset: a stray mem_rsp_valid in IDLE sets err and it stays set.
  - Reset asserted in DRAIN: out_valid drops the same cycle; err=0 after reset; a new start works normally.

Source files
------------

// File: rtl/mem_readback_engine_pkg.sv
// Shared memory-bus types and constants for the read-back engine and its bus neighbours
// (fetch stage, arbiter).
package mem_readback_engine_pkg;

    localparam int PHYS_ADDR_W = 21;
    localparam int WORD_BYTES  = 8;
    localparam int WORD_W      = 8 * WORD_BYTES;
    localparam int BYTE_IDX_W  = $clog2(WORD_BYTES);

    typedef logic [PHYS_ADDR_W-1:0] phys_memory_address_t;

    localparam phys_memory_address_t CODE_SEGMENT_START = 21'h000000;
    localparam phys_memory_address_t DATA_SEGMENT_START = 21'h100000;

    typedef struct packed {
        logic                 valid;
        phys_memory_address_t addr;
    } mem_read_req_t;

    typedef enum logic [1:0] {
        RB_IDLE,
        RB_ISSUE,
        RB_WAIT,
        RB_DRAIN
    } rb_state_t;

endpackage

// File: rtl/mem_readback_engine_unpacker.sv
// Holds one fetched bus word and streams its bytes out little-endian, starting at the
// byte offset given when the word is loaded.
module word_to_byte_unpacker
    import mem_readback_engine_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  word_load,
    input  logic [WORD_W-1:0]     word_data,
    input  logic [BYTE_IDX_W-1:0] word_skip,
    input  logic                  stream_end,
    output logic                  word_empty,
    output logic                  word_drained,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data
);

    logic [WORD_W-1:0]     buffer;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic                  buffer_full;
    logic                  byte_taken;

    assign byte_taken   = buffer_full && out_ready;
    assign word_drained = byte_taken && (byte_idx == BYTE_IDX_W'(WORD_BYTES - 1));
    assign word_empty   = !buffer_full;
    assign out_valid    = buffer_full;
    assign out_data     = buffer[8*byte_idx +: 8];

    // The buffer empties either at the top byte of the word or at the final byte of the dump.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer      <= '0;
            byte_idx    <= '0;
            buffer_full <= 1'b0;
        end else if (word_load) begin
            buffer      <= word_data;
            byte_idx    <= word_skip;
            buffer_full <= 1'b1;
        end else if (byte_taken) begin
            if (word_drained || stream_end) begin
                buffer_full <= 1'b0;
            end
            byte_idx <= byte_idx + BYTE_IDX_W'(1);
        end
    end

endmodule

// File: rtl/mem_readback_engine.sv
// Memory-bus initiator that reads a byte range out of DRAM, one word at a time, and
// emits it as a ready/valid byte stream.
module mem_readback_engine
    import mem_readback_engine_pkg::*;
#(
    parameter int ADDR_W = PHYS_ADDR_W,
    parameter int LEN_W  = PHYS_ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  byte_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [63:0]       mem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last
);

    rb_state_t             state, next_state;
    logic [ADDR_W-1:0]     cur_word;
    logic [LEN_W-1:0]      remaining;
    logic [BYTE_IDX_W-1:0] skip;

    logic start_dump, start_empty, rsp_accept, byte_taken, dump_end, final_byte;
    logic word_load, word_empty, word_drained;

    assign start_dump  = (state == RB_IDLE) && start && (byte_count != '0);
    assign start_empty = (state == RB_IDLE) && start && (byte_count == '0);
    assign rsp_accept  = (state == RB_WAIT) && mem_rsp_valid;
    assign final_byte  = (remaining == LEN_W'(1));
    assign byte_taken  = out_valid && out_ready;
    assign dump_end    = byte_taken && final_byte;
    assign mem_req_addr = cur_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            RB_IDLE:  if (start_dump) next_state = RB_ISSUE;
            RB_ISSUE: if (mem_req_ready) next_state = RB_WAIT;
            RB_WAIT:  if (mem_rsp_valid) next_state = RB_DRAIN;
            RB_DRAIN: begin
                if (dump_end) begin
                    next_state = RB_IDLE;
                end else if (word_drained) begin
                    next_state = RB_ISSUE;
                end
            end
            default:  next_state = RB_IDLE;
        endcase
    end

    // A request only goes out once the single word buffer has been fully drained.
    always_comb begin
        busy          = (state != RB_IDLE);
        mem_req_valid = (state == RB_ISSUE) && word_empty;
        word_load     = rsp_accept;
        out_last      = out_valid && final_byte;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_word  <= '0;
            remaining <= '0;
            skip      <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= start_empty || dump_end;
            if (mem_rsp_valid && (state != RB_WAIT)) begin
                err <= 1'b1;
            end
            if (start_dump) begin
                cur_word  <= {start_addr[ADDR_W-1:BYTE_IDX_W], BYTE_IDX_W'(0)};
                skip      <= start_addr[BYTE_IDX_W-1:0];
                remaining <= byte_count;
            end else begin
                if (rsp_accept) begin
                    skip <= '0;
                end
                if (byte_taken) begin
                    remaining <= remaining - LEN_W'(1);
                end
                // Address rollover past the top of memory is intentionally silent.
                if (word_drained && !dump_end) begin
                    cur_word <= cur_word + ADDR_W'(WORD_BYTES);
                end
            end
        end
    end

    word_to_byte_unpacker u_unpacker (
        .clk          (clk),
        .reset        (reset),
        .word_load    (word_load),
        .word_data    (mem_rsp_data),
        .word_skip    (skip),
        .stream_end   (final_byte),
        .word_empty   (word_empty),
        .word_drained (word_drained),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

endmodule
